foc_sample_master: RTL and testbench

Synthesizable initiator for the FOC core (`top`) request interface.
- Loads the D/Q PID coefficients through the `pid_*` write ports.
- Forwards ADC/resolver samples to the core as single-cycle `valid` pulses, holds them stable, and waits for the core's `ready`.
- Sits between the ADC/resolver front end and `top`, replacing bench-driven stimulus on the real device.

---
 rtl/foc_pkg.sv | 29 ++
 rtl/foc_sample_master_if.sv | 27 ++
 rtl/foc_sample_master_slot.sv | 40 ++++
 rtl/foc_sample_master.sv | 192 +++++++++++++++++++
 tb/tb_foc_sample_master.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/foc_pkg.sv
// Shared types and constants for the FOC sample master and its sub-blocks.
package foc_pkg;

    // Controller sequencing: coefficient load, then the sample/ready handshake loop.
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        CFG_KP      = 3'd1,
        CFG_KI      = 3'd2,
        WAIT_SAMPLE = 3'd3,
        WAIT_READY  = 3'd4
    } state_e;

    // Coefficient addresses inside each axis PID block.
    localparam int PID_ADDR_KP = 0;
    localparam int PID_ADDR_KI = 1;

    // Default data width of angle, currents and coefficients.
    localparam int FOC_D_WIDTH = 19;

    // One ADC/resolver sample; packs to {curr_c, curr_b, curr_a, angle}, matching
    // the {adc_curr, adc_angle} concatenation with phase A in the low current bits.
    typedef struct packed {
        logic [FOC_D_WIDTH-1:0] curr_c;
        logic [FOC_D_WIDTH-1:0] curr_b;
        logic [FOC_D_WIDTH-1:0] curr_a;
        logic [FOC_D_WIDTH-1:0] angle;
    } sample_t;

endpackage

// File: rtl/foc_sample_master_if.sv
// Request and coefficient-write bus between the sample master and the FOC core.
interface foc_sample_master_if #(
    parameter int D_WIDTH = 19
);
    logic                   valid;
    logic                   ready;
    logic [D_WIDTH-1:0]     angle_out;
    logic [3*D_WIDTH-1:0]   curr_out;
    logic                   pid_d_wen;
    logic                   pid_q_wen;
    logic [D_WIDTH-1:0]     pid_d_addr;
    logic [D_WIDTH-1:0]     pid_q_addr;
    logic [D_WIDTH-1:0]     pid_d_data;
    logic [D_WIDTH-1:0]     pid_q_data;

    modport master (
        output valid, angle_out, curr_out,
        output pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
        input  ready
    );

    modport slave (
        input  valid, angle_out, curr_out,
        input  pid_d_wen, pid_q_wen, pid_d_addr, pid_q_addr, pid_d_data, pid_q_data,
        output ready
    );
endinterface

// File: rtl/foc_sample_master_slot.sv
// One-entry pending-sample buffer: newest sample wins, lost samples are counted
// in a saturating overrun counter.
module sample_slot #(
    parameter int W         = 76,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstb,
    input  logic                 push,
    input  logic                 pop,
    input  logic [W-1:0]         wdata,
    output logic                 full,
    output logic [W-1:0]         rdata,
    output logic [CNT_WIDTH-1:0] overrun_cnt
);

    // Store/overwrite on push, free on pop; a push that replaces an unread entry is an overrun.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            // NOTE: the slot data is a single register, not a memory array, so it is
            // reset along with its flag and the downstream outputs never see X.
            full        <= 1'b0;
            rdata       <= '0;
            overrun_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from the
            // pre-edge values, so the order of these statements does not matter.
            if (push) begin
                rdata <= wdata;
                full  <= 1'b1;
                // Popping in the same cycle means the old entry was forwarded, not lost.
                if (full && !pop && (overrun_cnt != '1))
                    overrun_cnt <= overrun_cnt + 1'b1;
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/foc_sample_master.sv
// Initiator for the FOC core: loads D/Q PID gains, then forwards ADC/resolver
// samples as single-cycle valid pulses and waits for the core's ready edge.
module foc_sample_master
    import foc_pkg::*;
#(
    parameter int D_WIDTH        = FOC_D_WIDTH,
    parameter int Q_BITS         = 15,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   cfg_start,
    input  logic [2*D_WIDTH-1:0]   kp_in,
    input  logic [2*D_WIDTH-1:0]   ki_in,
    input  logic                   adc_valid,
    input  logic [D_WIDTH-1:0]     adc_angle,
    input  logic [3*D_WIDTH-1:0]   adc_curr,
    foc_sample_master_if.master    core,
    output logic                   cfg_done,
    output logic                   busy,
    output logic                   err_timeout,
    output logic [CNT_WIDTH-1:0]   overrun_cnt
);

    localparam int SW    = 4 * D_WIDTH;
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Q_BITS only documents the number format; reject settings that cannot describe it.
    if (Q_BITS >= D_WIDTH || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("foc_sample_master: Q_BITS must be below D_WIDTH and TIMEOUT_CYCLES at least 2");
    end

    state_e                 state;
    logic                   ready_q;
    logic                   ready_rise;
    logic                   cfg_pend;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [2*D_WIDTH-1:0]   kp_r, ki_r, kp_src, ki_src;

    logic                   push, pop, fwd_slot, fwd_new, start_cfg;
    logic                   slot_full;
    logic [SW-1:0]          slot_data, adc_sample, fwd_sample;

    logic                   valid_r, wen_r;
    logic [D_WIDTH-1:0]     angle_r, addr_r, data_d_r, data_q_r;
    logic [3*D_WIDTH-1:0]   curr_r;

    assign ready_rise = core.ready & ~ready_q;
    assign adc_sample = {adc_curr, adc_angle};
    assign fwd_sample = fwd_slot ? slot_data : adc_sample;

    // A fresh cfg_start carries the gains on its own inputs; a deferred one uses the captured copy.
    assign kp_src = cfg_start ? kp_in : kp_r;
    assign ki_src = cfg_start ? ki_in : ki_r;

    assign core.valid      = valid_r;
    assign core.angle_out  = angle_r;
    assign core.curr_out   = curr_r;
    assign core.pid_d_wen  = wen_r;
    assign core.pid_q_wen  = wen_r;
    assign core.pid_d_addr = addr_r;
    assign core.pid_q_addr = addr_r;
    assign core.pid_d_data = data_d_r;
    assign core.pid_q_data = data_q_r;

    // Decide this cycle's action: start a load, forward a sample, or park one in the slot.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a value unassigned and no latch is inferred.
        push      = 1'b0;
        pop       = 1'b0;
        fwd_slot  = 1'b0;
        fwd_new   = 1'b0;
        start_cfg = 1'b0;
        case (state)
            CFG_KP, CFG_KI, WAIT_READY: begin
                push = adc_valid;
            end
            default: begin
                if (!cfg_done) begin
                    // Unconfigured: samples are dropped without being counted.
                    start_cfg = cfg_start;
                end else if (cfg_start || cfg_pend) begin
                    start_cfg = 1'b1;
                    push      = adc_valid;
                end else if (slot_full) begin
                    fwd_slot = 1'b1;
                    pop      = 1'b1;
                    push     = adc_valid;
                end else begin
                    fwd_new = adc_valid;
                end
            end
        endcase
    end

    sample_slot #(
        .W         (SW),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_slot (
        .clk         (clk),
        .rstb        (rstb),
        .push        (push),
        .pop         (pop),
        .wdata       (adc_sample),
        .full        (slot_full),
        .rdata       (slot_data),
        .overrun_cnt (overrun_cnt)
    );

    // Sequencer: two coefficient writes, then valid/ready handshakes with timeout.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= IDLE;
            ready_q     <= 1'b1;    // a ready held high through reset is not an edge
            cfg_pend    <= 1'b0;
            tmo_cnt     <= '0;
            kp_r        <= '0;
            ki_r        <= '0;
            valid_r     <= 1'b0;
            angle_r     <= '0;
            curr_r      <= '0;
            wen_r       <= 1'b0;
            addr_r      <= '0;
            data_d_r    <= '0;
            data_q_r    <= '0;
            cfg_done    <= 1'b0;
            busy        <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            ready_q <= core.ready;
            valid_r <= 1'b0;
            case (state)
                CFG_KP: begin
                    addr_r   <= D_WIDTH'(PID_ADDR_KI);
                    data_d_r <= ki_r[D_WIDTH-1:0];
                    data_q_r <= ki_r[2*D_WIDTH-1:D_WIDTH];
                    state    <= CFG_KI;
                end
                CFG_KI: begin
                    wen_r    <= 1'b0;
                    cfg_done <= 1'b1;
                    state    <= WAIT_SAMPLE;
                end
                WAIT_READY: begin
                    // A load requested mid-handshake waits until the core is released.
                    if (cfg_start) begin
                        cfg_pend <= 1'b1;
                        kp_r     <= kp_in;
                        ki_r     <= ki_in;
                    end
                    if (ready_rise) begin
                        busy  <= 1'b0;
                        state <= WAIT_SAMPLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_timeout <= 1'b1;
                        busy        <= 1'b0;
                        state       <= WAIT_SAMPLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                IDLE, WAIT_SAMPLE: begin
                    if (start_cfg) begin
                        kp_r     <= kp_src;
                        ki_r     <= ki_src;
                        cfg_pend <= 1'b0;
                        wen_r    <= 1'b1;
                        addr_r   <= D_WIDTH'(PID_ADDR_KP);
                        data_d_r <= kp_src[D_WIDTH-1:0];
                        data_q_r <= kp_src[2*D_WIDTH-1:D_WIDTH];
                        state    <= CFG_KP;
                    end else if (fwd_slot || fwd_new) begin
                        // Data registers load on the same edge that raises valid.
                        angle_r <= fwd_sample[D_WIDTH-1:0];
                        curr_r  <= fwd_sample[SW-1:D_WIDTH];
                        valid_r <= 1'b1;
                        busy    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= WAIT_READY;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_foc_sample_master.sv
// Self-checking bench for foc_sample_master: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model.
module tb_foc_sample_master;
    import foc_pkg::*;

    localparam int D  = 19;
    localparam int T  = 16;
    localparam int CW = 8;

    logic            clk;
    logic            rstb;
    logic            cfg_start;
    logic [2*D-1:0]  kp_in, ki_in;
    logic            adc_valid;
    logic [D-1:0]    adc_angle;
    logic [3*D-1:0]  adc_curr;
    logic            cfg_done, busy, err_timeout;
    logic [CW-1:0]   overrun_cnt;

    foc_sample_master_if #(.D_WIDTH(D)) core_if ();

    foc_sample_master #(
        .D_WIDTH        (D),
        .Q_BITS         (15),
        .TIMEOUT_CYCLES (T),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .cfg_start   (cfg_start),
        .kp_in       (kp_in),
        .ki_in       (ki_in),
        .adc_valid   (adc_valid),
        .adc_angle   (adc_angle),
        .adc_curr    (adc_curr),
        .core        (core_if),
        .cfg_done    (cfg_done),
        .busy        (busy),
        .err_timeout (err_timeout),
        .overrun_cnt (overrun_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks what the core must see: configured or not, a coefficient write in
    // progress (1 = Kp shown, 2 = Ki shown), a request in flight, one parked sample.
    logic        m_valid, m_busy, m_cfg_done, m_err, m_wen;
    int          m_ovr;
    logic [D-1:0] m_addr, m_dd, m_dq, m_angle;
    logic [3*D-1:0] m_curr;
    int          m_phase;
    logic        m_cfg_pend;
    logic [2*D-1:0] m_kp, m_ki;
    sample_t     m_slot;
    logic        m_slot_full;
    logic        m_ready_prev;
    longint      edge_n, issue_edge;

    task automatic model_reset();
        m_valid = 0; m_busy = 0; m_cfg_done = 0; m_err = 0; m_wen = 0; m_ovr = 0;
        m_addr = 0; m_dd = 0; m_dq = 0; m_angle = 0; m_curr = 0; m_phase = 0;
        m_cfg_pend = 0; m_kp = 0; m_ki = 0; m_slot = '0; m_slot_full = 0;
        m_ready_prev = 1; edge_n = 0; issue_edge = 0;
    endtask

    task automatic model_park(input sample_t s);
        if (m_slot_full && m_ovr < 255) m_ovr++;
        m_slot = s;
        m_slot_full = 1;
    endtask

    task automatic model_issue(input sample_t s);
        m_valid    = 1;
        m_angle    = s.angle;
        m_curr     = {s.curr_c, s.curr_b, s.curr_a};
        m_busy     = 1;
        issue_edge = edge_n;
    endtask

    task automatic model_step();
        sample_t s;
        logic    rise;
        edge_n++;
        rise = core_if.ready && !m_ready_prev;
        m_ready_prev = core_if.ready;
        s.angle = adc_angle;
        {s.curr_c, s.curr_b, s.curr_a} = adc_curr;
        m_valid = 0;
        if (m_phase == 1) begin
            m_addr = 1; m_dd = m_ki[D-1:0]; m_dq = m_ki[2*D-1:D]; m_phase = 2;
            if (adc_valid) model_park(s);
        end else if (m_phase == 2) begin
            m_wen = 0; m_cfg_done = 1; m_phase = 0;
            if (adc_valid) model_park(s);
        end else if (m_busy) begin
            if (cfg_start) begin m_cfg_pend = 1; m_kp = kp_in; m_ki = ki_in; end
            if (adc_valid) model_park(s);
            if (rise) m_busy = 0;
            else if (edge_n - issue_edge == T) begin m_err = 1; m_busy = 0; end
        end else if (cfg_start || m_cfg_pend) begin
            if (cfg_start) begin m_kp = kp_in; m_ki = ki_in; end
            m_cfg_pend = 0; m_wen = 1; m_addr = 0;
            m_dd = m_kp[D-1:0]; m_dq = m_kp[2*D-1:D]; m_phase = 1;
            if (adc_valid && m_cfg_done) model_park(s);
        end else if (m_cfg_done) begin
            if (m_slot_full) begin
                model_issue(m_slot);
                if (adc_valid) m_slot = s;
                else m_slot_full = 0;
            end else if (adc_valid) begin
                model_issue(s);
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rstb);
            if (!rstb) model_reset();
            else model_step();
        end
    end

    // Every cycle out of reset, compare the DUT's outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rstb === 1'b1) begin
                check("valid", core_if.valid, m_valid);
                check("busy", busy, m_busy);
                check("cfg_done", cfg_done, m_cfg_done);
                check("err_timeout", err_timeout, m_err);
                check("overrun_cnt", overrun_cnt, m_ovr[CW-1:0]);
                check("pid_d_wen", core_if.pid_d_wen, m_wen);
                check("pid_q_wen", core_if.pid_q_wen, m_wen);
                check("angle_out", core_if.angle_out, m_angle);
                check("curr_out", core_if.curr_out, m_curr);
                if (m_wen) begin
                    check("pid_d_addr", core_if.pid_d_addr, m_addr);
                    check("pid_q_addr", core_if.pid_q_addr, m_addr);
                    check("pid_d_data", core_if.pid_d_data, m_dd);
                    check("pid_q_data", core_if.pid_q_data, m_dq);
                end
            end
        end
    end

    // ---------------- stimulus with literal expectations ----------------
    task automatic send(input logic [D-1:0] ang, input logic [3*D-1:0] cur);
        adc_valid = 1'b1; adc_angle = ang; adc_curr = cur;
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    task automatic do_config(input logic [2*D-1:0] kp, input logic [2*D-1:0] ki);
        cfg_start = 1'b1; kp_in = kp; ki_in = ki;
        @(negedge clk);
        cfg_start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstb = 1'b0; cfg_start = 1'b0; kp_in = '0; ki_in = '0;
        adc_valid = 1'b0; adc_angle = '0; adc_curr = '0; core_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst valid", core_if.valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst cfg_done", cfg_done, 1'b0);
        check("rst ovr", overrun_cnt, 8'd0);
        rstb = 1'b1;
        @(negedge clk);

        // Samples before any configuration are dropped and not counted.
        adc_valid = 1'b1; adc_angle = 19'd7;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("precfg valid", core_if.valid, 1'b0);
        end
        adc_valid = 1'b0;
        check("precfg ovr", overrun_cnt, 8'd0);

        // Coefficient load; inputs scrambled right after cfg_start to prove capture.
        cfg_start = 1'b1; kp_in = {19'd4096, 19'd4096}; ki_in = {19'd512, 19'd512};
        @(negedge clk);
        cfg_start = 1'b0; kp_in = '1; ki_in = '1;
        check("cfg kp wen", core_if.pid_d_wen, 1'b1);
        check("cfg kp addr", core_if.pid_q_addr, 19'd0);
        check("cfg kp data_d", core_if.pid_d_data, 19'd4096);
        check("cfg kp data_q", core_if.pid_q_data, 19'd4096);
        @(negedge clk);
        check("cfg ki addr", core_if.pid_d_addr, 19'd1);
        check("cfg ki data_d", core_if.pid_d_data, 19'd512);
        check("cfg ki data_q", core_if.pid_q_data, 19'd512);
        @(negedge clk);
        check("cfg wen off", core_if.pid_q_wen, 1'b0);
        check("cfg done", cfg_done, 1'b1);

        // Signed currents pass through untouched and hold through the handshake.
        adc_valid = 1'b1; adc_angle = 19'h01000; adc_curr = {19'd0, 19'h7C000, 19'd16384};
        @(negedge clk);
        adc_valid = 1'b0; adc_angle = '0; adc_curr = '1;
        check("fwd valid", core_if.valid, 1'b1);
        check("fwd angle", core_if.angle_out, 19'h01000);
        check("fwd curr", core_if.curr_out, {19'd0, 19'h7C000, 19'd16384});
        check("fwd busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold valid", core_if.valid, 1'b0);
            check("hold curr", core_if.curr_out, {19'd0, 19'h7C000, 19'd16384});
            check("hold busy", busy, 1'b1);
        end
        core_if.ready = 1'b1;
        @(negedge clk);
        core_if.ready = 1'b0;
        check("ready busy", busy, 1'b0);
        @(negedge clk);

        // Handshake timeout exactly T cycles after valid.
        send(19'h00123, 57'd5);
        check("tmo valid", core_if.valid, 1'b1);
        repeat (T - 1) @(negedge clk);
        check("tmo busy before", busy, 1'b1);
        check("tmo err before", err_timeout, 1'b0);
        @(negedge clk);
        check("tmo err", err_timeout, 1'b1);
        check("tmo busy", busy, 1'b0);
        send(19'h00456, 57'd6);
        check("after tmo valid", core_if.valid, 1'b1);
        check("after tmo angle", core_if.angle_out, 19'h00456);
        core_if.ready = 1'b1;
        @(negedge clk);
        core_if.ready = 1'b0;
        @(negedge clk);

        // Two samples during WAIT_READY: the second survives, one overrun.
        send(19'd10, 57'd10);
        send(19'd11, 57'd11);
        send(19'd12, 57'd12);
        core_if.ready = 1'b1;
        @(negedge clk);
        core_if.ready = 1'b0;
        check("ovr busy", busy, 1'b0);
        check("ovr cnt", overrun_cnt, 8'd1);
        @(negedge clk);
        check("ovr fwd valid", core_if.valid, 1'b1);
        check("ovr fwd angle", core_if.angle_out, 19'd12);
        core_if.ready = 1'b1;
        @(negedge clk);
        core_if.ready = 1'b0;

        // Continuous samples without ready: counter saturates.
        adc_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            adc_angle = 19'($urandom);
            @(negedge clk);
        end
        adc_valid = 1'b0;
        check("ovr sat", overrun_cnt, 8'd255);
        repeat (40) @(negedge clk);

        // Load requested mid-handshake: writes after ready, before the parked sample.
        send(19'h21, 57'd1);
        check("pend first valid", core_if.valid, 1'b1);
        adc_valid = 1'b1; adc_angle = 19'h22; adc_curr = 57'd2;
        cfg_start = 1'b1; kp_in = {19'd3, 19'd2}; ki_in = {19'd5, 19'd4};
        @(negedge clk);
        adc_valid = 1'b0; cfg_start = 1'b0; kp_in = '0; ki_in = '0;
        check("pend no wen", core_if.pid_d_wen, 1'b0);
        core_if.ready = 1'b1;
        @(negedge clk);
        core_if.ready = 1'b0;
        check("pend busy", busy, 1'b0);
        check("pend wen idle", core_if.pid_d_wen, 1'b0);
        @(negedge clk);
        check("pend kp wen", core_if.pid_d_wen, 1'b1);
        check("pend kp d", core_if.pid_d_data, 19'd2);
        check("pend kp q", core_if.pid_q_data, 19'd3);
        check("pend kp no valid", core_if.valid, 1'b0);
        @(negedge clk);
        check("pend ki d", core_if.pid_d_data, 19'd4);
        check("pend ki q", core_if.pid_q_data, 19'd5);
        @(negedge clk);
        check("pend wen off", core_if.pid_d_wen, 1'b0);
        check("pend no valid", core_if.valid, 1'b0);
        @(negedge clk);
        check("pend fwd valid", core_if.valid, 1'b1);
        check("pend fwd angle", core_if.angle_out, 19'h22);

        // Asynchronous reset mid-handshake, with ready held high across it.
        #2;
        rstb = 1'b0; core_if.ready = 1'b1;
        #1;
        check("arst valid", core_if.valid, 1'b0);
        check("arst busy", busy, 1'b0);
        check("arst cfg_done", cfg_done, 1'b0);
        check("arst err", err_timeout, 1'b0);
        check("arst ovr", overrun_cnt, 8'd0);
        check("arst angle", core_if.angle_out, 19'd0);
        check("arst curr", core_if.curr_out, 57'd0);
        check("arst wen", core_if.pid_d_wen, 1'b0);
        check("arst data", core_if.pid_q_data, 19'd0);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        do_config({19'd9, 19'd8}, {19'd7, 19'd6});
        @(negedge clk);
        send(19'h33, 57'd3);
        check("rh valid", core_if.valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rh busy held", busy, 1'b1);
        end
        core_if.ready = 1'b0;
        @(negedge clk);
        core_if.ready = 1'b1;
        @(negedge clk);
        check("rh busy released", busy, 1'b0);
        core_if.ready = 1'b0;

        // Randomized traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cfg_start = ($urandom_range(0, 63) == 0);
            kp_in     = {19'($urandom), 19'($urandom)};
            ki_in     = {19'($urandom), 19'($urandom)};
            adc_valid = ($urandom_range(0, 2) == 0);
            adc_angle = 19'($urandom);
            adc_curr  = {19'($urandom), 19'($urandom), 19'($urandom)};
            if ($urandom_range(0, 4) == 0) core_if.ready = ~core_if.ready;
        end
        @(negedge clk);
        cfg_start = 1'b0; adc_valid = 1'b0; core_if.ready = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
